// File: rtl/feedback_avg.sv
// Measures "FIFO below half" cycles per frame and averages them over 2^AVG_LOG2 frames.
// sof is synchronised into clk; fb_value is the windowed sum (AVG_LOG2 fractional bits).
module feedback_avg #(
  parameter int CNT_W       = 16,
  parameter int AVG_LOG2    = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      sof,
  input  logic                      half_n,
  input  logic                      ovf_clr,
  output logic [CNT_W+AVG_LOG2-1:0] fb_value,
  output logic                      fb_valid,
  output logic                      ovf,
  output logic [1:0]                dbg_state
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);

  // dbg_state encoding: 0 = IDLE, 1 = SYNC, 2 = RUN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sof_sync;
  logic [SYNC_STAGES-1:0] sync_vld;
  logic                   sof_prev;
  logic                   sof_armed;
  logic                   sof_pulse;

  logic [CNT_W-1:0] frame_cnt;
  logic [ACC_W-1:0] acc;
  logic [IDX_W-1:0] idx;

  logic             sat;
  logic [CNT_W-1:0] first_cnt;
  logic [ACC_W-1:0] sample_ext;

  // sync_vld tracks which stages hold real samples; an edge is only accepted
  // once a genuine 0 has been seen, so reset release never fakes a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sof_sync  <= '0;
      sync_vld  <= '0;
      sof_prev  <= 1'b0;
      sof_armed <= 1'b0;
      sof_pulse <= 1'b0;
    end else begin
      sof_sync  <= {sof_sync[SYNC_STAGES-2:0], sof};
      sync_vld  <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
      sof_prev  <= sof_sync[SYNC_STAGES-1];
      if (sync_vld[SYNC_STAGES-1] && !sof_sync[SYNC_STAGES-1]) begin
        sof_armed <= 1'b1;
      end
      sof_pulse <= sof_sync[SYNC_STAGES-1] & ~sof_prev & sof_armed;
    end
  end

  assign sat        = enable && (state == RUN) && !sof_pulse && !half_n &&
                      (frame_cnt == {CNT_W{1'b1}});
  assign first_cnt  = {{(CNT_W-1){1'b0}}, ~half_n};
  assign sample_ext = ACC_W'(frame_cnt);
  assign dbg_state  = state;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable) next_state = SYNC;
      SYNC:    if (sof_pulse) next_state = RUN;
      RUN:     if (sat) next_state = SYNC;
      default: next_state = IDLE;
    endcase
    if (!enable) next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      acc       <= '0;
      idx       <= '0;
      fb_value  <= '0;
      fb_valid  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      fb_valid <= 1'b0;
      if (sat) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end

      if (!enable || state == IDLE) begin
        frame_cnt <= '0;
        acc       <= '0;
        idx       <= '0;
      end else if (state == SYNC) begin
        if (sof_pulse) frame_cnt <= first_cnt;
      end else if (sof_pulse) begin
        // The pulse cycle itself belongs to the new frame.
        frame_cnt <= first_cnt;
        if (idx == IDX_LAST) begin
          fb_value <= acc + sample_ext;
          fb_valid <= 1'b1;
          acc      <= '0;
          idx      <= '0;
        end else begin
          acc <= acc + sample_ext;
          idx <= IDX_W'(idx + 1'b1);
        end
      end else if (!half_n) begin
        if (sat) begin
          frame_cnt <= '0;
          acc       <= '0;
          idx       <= '0;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_feedback_avg.sv
// Randomised and directed bench for feedback_avg: two instances (16-bit/window 4 and
// 8-bit/window 1) checked against a frame-level reference model through expected queues.
module tb_feedback_avg;

  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst_n, enable, sof, half_n, ovf_clr;

  logic [17:0] fb0;
  logic        fbv0, ovf0;
  logic [1:0]  st0;
  logic [7:0]  fb1;
  logic        fbv1, ovf1;
  logic [1:0]  st1;

  feedback_avg #(.CNT_W(16), .AVG_LOG2(2), .SYNC_STAGES(SS)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sof(sof), .half_n(half_n),
    .ovf_clr(ovf_clr), .fb_value(fb0), .fb_valid(fbv0), .ovf(ovf0), .dbg_state(st0)
  );

  feedback_avg #(.CNT_W(8), .AVG_LOG2(0), .SYNC_STAGES(SS)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sof(sof), .half_n(half_n),
    .ovf_clr(ovf_clr), .fb_value(fb1), .fb_valid(fbv1), .ovf(ovf1), .dbg_state(st1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  // Reference model: frame-level view. A frame starts on the cycle the
  // synchronised sof edge takes effect; its sample is the number of half_n-low cycles in it.
  int     cw[2] = '{16, 8};
  int     al[2] = '{2, 0};
  int     m_st[2];
  int     m_n[2];
  longint m_cnt[2];
  longint m_sum[2];
  longint m_fb[2];
  bit     m_ovf[2];
  bit     sof_hist[$];
  bit     tgl = 1'b0;
  bit     mon_en = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic int q_size(int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [31:0] q_pop(int i);
    if (i == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  function automatic void q_push(int i, logic [31:0] v);
    if (i == 0) exp_q0.push_back(v);
    else exp_q1.push_back(v);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_n[i] = 0; m_cnt[i] = 0; m_sum[i] = 0; m_fb[i] = 0; m_ovf[i] = 1'b0;
    end
    sof_hist.delete();
    exp_q0.delete();
    exp_q1.delete();
  endfunction

  function automatic void model_step(int i, bit en, bit hn, bit clr, bit pulse);
    bit     sat = 1'b0;
    longint first = hn ? 0 : 1;
    if (!en) begin
      m_st[i] = 0; m_cnt[i] = 0; m_sum[i] = 0; m_n[i] = 0;
    end else if (m_st[i] == 0) begin
      m_st[i] = 1;
    end else if (m_st[i] == 1) begin
      if (pulse) begin
        m_st[i] = 2;
        m_cnt[i] = first;
      end
    end else if (pulse) begin
      m_sum[i] += m_cnt[i];
      m_n[i]++;
      m_cnt[i] = first;
      if (m_n[i] == (1 << al[i])) begin
        m_fb[i] = m_sum[i];
        q_push(i, 32'(m_sum[i]));
        m_sum[i] = 0;
        m_n[i] = 0;
      end
    end else if (!hn) begin
      if (m_cnt[i] == (64'd1 << cw[i]) - 1) begin
        sat = 1'b1;
        m_st[i] = 1; m_cnt[i] = 0; m_sum[i] = 0; m_n[i] = 0;
      end else begin
        m_cnt[i]++;
      end
    end
    if (sat) m_ovf[i] = 1'b1;
    else if (clr) m_ovf[i] = 1'b0;
  endfunction

  // One clock: drive, let the edge sample, then advance the model.
  task automatic cycle(bit en, bit hn, bit s, bit clr);
    int  l;
    bit  pulse;
    enable = en; half_n = hn; sof = s; ovf_clr = clr;
    @(posedge clk);
    if (rst_n) begin
      sof_hist.push_back(s);
      l = sof_hist.size() - 1;
      pulse = (l >= 4) && sof_hist[l-SS-1] && !sof_hist[l-SS-2];
      model_step(0, en, hn, clr, pulse);
      model_step(1, en, hn, clr, pulse);
    end
    #2;
  endtask

  task automatic idle(int n);
    repeat (n) cycle(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // mode 0: half_n always low, 1: toggling, 2: low only on the frame-start cycle, 3: random
  // clr_mode 0: never, 1: always, 2: random
  task automatic frame(int len, int mode, int clr_mode);
    bit hn, clr;
    for (int j = 0; j < len; j++) begin
      tgl = ~tgl;
      case (mode)
        0:       hn = 1'b0;
        1:       hn = tgl;
        2:       hn = (j == SS + 1) ? 1'b0 : 1'b1;
        default: hn = 1'($urandom_range(0, 1));
      endcase
      case (clr_mode)
        0:       clr = 1'b0;
        1:       clr = 1'b1;
        default: clr = ($urandom_range(0, 7) == 0);
      endcase
      cycle(1'b1, hn, (j < len / 2), clr);
    end
  endtask

  task automatic chk_inst(int i, logic v, logic [31:0] val, logic o, logic [1:0] st);
    if (v === 1'b1) begin
      if (q_size(i) == 0) begin
        checks++;
        errors++;
        $display("FAIL fb_valid_unexpected inst=%0d actual=1 expected=0", i);
      end else begin
        check($sformatf("fb_value_inst%0d", i), val, q_pop(i));
      end
    end else if (q_size(i) != 0) begin
      checks++;
      errors++;
      $display("FAIL fb_valid_missing inst=%0d actual=%b expected=1 value=%0d", i, v, q_pop(i));
    end
    check($sformatf("ovf_inst%0d", i), o, m_ovf[i]);
    check($sformatf("state_inst%0d", i), st, m_st[i]);
    check($sformatf("fb_hold_inst%0d", i), val, m_fb[i]);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk_inst(0, fbv0, 32'(fb0), ovf0, st0);
      chk_inst(1, fbv1, 32'(fb1), ovf1, st1);
    end
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; sof = 1'b1; half_n = 1'b0; ovf_clr = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    mon_en = 1'b1;

    // Reset with sof high and half_n low; release with sof still high.
    repeat (5) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("reset_fb_value", fb0, 18'd0);
    check("reset_fb_valid", fbv0, 1'b0);
    check("reset_ovf", ovf0, 1'b0);
    rst_n = 1'b1;
    repeat (60) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("no_pulse_after_release", st0, 2'd1);
    idle(10);

    // Full rate, 1000-cycle frames.
    repeat (9) frame(1000, 0, 0);
    check("full_rate_value", fb0, 18'd4000);
    idle(5);

    // 50% duty.
    repeat (9) frame(1000, 1, 0);
    check("half_duty_value", fb0, 18'd2000);
    idle(5);

    // Enable dropped two frames into a window.
    repeat (3) frame(400, 0, 0);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) frame(400, 0, 0);
    check("enable_drop_value", fb0, 18'd1600);
    idle(5);

    // Only the frame-start cycle has half_n low.
    repeat (5) frame(60, 2, 0);
    check("edge_timing_value", fb0, 18'd4);
    idle(5);

    // Missing sof on the 8-bit instance.
    frame(100, 0, 0);
    repeat (300) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("ovf8_set", ovf1, 1'b1);
    check("ovf8_state_sync", st1, 2'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("ovf8_clr", ovf1, 1'b0);
    idle(5);
    // Saturation while ovf_clr is held: set must win on that cycle.
    frame(100, 0, 1);
    repeat (300) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    idle(5);

    // Randomised frames, enable drops, one mid-window reset.
    for (int k = 0; k < 40; k++) begin
      frame($urandom_range(20, 300), $urandom_range(0, 3), 2);
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 20)) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      if (k == 20) begin
        rst_n = 1'b0;
        model_reset();
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(5);
      end
    end
    idle(10);
    mon_en = 1'b0;

    check("queue0_drained", 32'(exp_q0.size()), 32'd0);
    check("queue1_drained", 32'(exp_q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/feedback_avg.md
FEEDBACK_AVG -- requirements
Module: feedback_avg

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the per-frame cycle counter.
REQ-002 SHALL have parameter AVG_LOG2, default 3: averaging window of 2^AVG_LOG2 frames, also the number of fractional bits in fb_value.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for sof (minimum 2).
REQ-004 SHALL have port clk, input, 1: clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1: measurement enable, clk domain.
REQ-007 SHALL have port sof, input, 1: start-of-frame level, asynchronous to clk; each rising edge marks one frame boundary.
REQ-008 SHALL have port half_n, input, 1: active-low "FIFO below half" level, clk domain; each clk cycle with half_n low counts as 1.
REQ-009 SHALL have port ovf_clr, input, 1: synchronous clear of ovf.
REQ-010 SHALL have port fb_value, output, CNT_W+AVG_LOG2: registered sum over the last complete window (fixed-point average).
REQ-011 SHALL have port fb_valid, output, 1: one-cycle pulse when fb_value updates.
REQ-012 SHALL have port ovf, output, 1: sticky frame-counter saturation flag.

Function
REQ-013 SHALL pass sof through SYNC_STAGES flops, then a rising-edge detector producing sof_pulse; sof_pulse SHALL be asserted exactly SYNC_STAGES+1 cycles after the sof rise is first sampled.
REQ-014 SHALL implement states IDLE, SYNC and RUN.
REQ-015 State transitions: IDLE->SYNC when enable=1; SYNC->RUN on sof_pulse; any state->IDLE when enable=0, taking priority over all other events.
REQ-016 IDLE: frame counter, accumulator and window index cleared; fb_value held; no fb_valid.
REQ-017 SYNC: nothing counted; the partial frame before the first sof_pulse is discarded.
REQ-018 RUN, non-pulse cycle: frame_cnt += 1 when half_n=0, otherwise unchanged.
REQ-019 RUN, sof_pulse cycle: the completed sample is the frame_cnt value before the pulse cycle; frame_cnt loads 1 if half_n=0, else 0; every cycle is counted in exactly one frame.
REQ-020 SYNC->RUN transition cycle: frame_cnt loads 1 if half_n=0, else 0.
REQ-021 Each completed sample SHALL be added to an accumulator of width CNT_W+AVG_LOG2 (cannot overflow), and the window index SHALL increment modulo 2^AVG_LOG2.
REQ-022 When the sample completing index 2^AVG_LOG2-1 arrives: fb_value <= acc + sample, acc <= 0, index <= 0, and fb_valid=1 in the next cycle only.
REQ-023 Saturation: in RUN, if frame_cnt = 2^CNT_W-1 and an increment is due (missing SOF), then ovf <= 1, acc, index and frame_cnt are cleared, the state goes to SYNC, and fb_value is held with no fb_valid.
REQ-024 ovf SHALL remain set until ovf_clr=1; if ovf_clr and a new saturation occur in the same cycle, ovf SHALL be 1 (set wins).
REQ-025 AVG_LOG2=0 SHALL be legal: fb_value updates every frame.
REQ-026 sof_pulse and enable falling in the same cycle SHALL give IDLE with no fb_valid.

Reset
REQ-027 On rst_n=0: state=IDLE; frame_cnt, acc, index, fb_value, fb_valid, ovf and synchroniser flops all 0; outputs SHALL be valid 0 during reset.
REQ-028 Reset release SHALL NOT generate sof_pulse even if sof=1 (synchroniser flops reset to 0; first edge counted only after a sampled 0->1).
REQ-029 Reset asserted mid-window SHALL discard all partial data with no fb_valid.

Verification (CNT_W=16, AVG_LOG2=2, SYNC_STAGES=2 unless stated)
REQ-030 Reset: rst_n low with sof=1, half_n=0 -> fb_value=0, fb_valid=0, ovf=0; after release with sof held 1 -> no fb_valid ever.
REQ-031 Full rate: enable=1, half_n=0, sof period 1000 cycles -> first fb_valid after 5th sof_pulse, fb_value=4000 (0x0FA0), then one pulse every 4000 cycles.
REQ-032 50% duty: half_n toggling every cycle, sof period 1000 -> fb_value=2000 per window, ±0 error (no lost or double-counted cycles).
REQ-033 Missing SOF: CNT_W=8, half_n=0, no sof after entering RUN -> ovf=1 when the 256th increment is due, state SYNC, fb_value unchanged; ovf_clr pulse -> ovf=0.
REQ-034 Enable drop: deassert enable for 10 cycles after 2 frames of a window, then re-enable -> no fb_valid for the aborted window; next fb_valid after 5 further sof_pulses with correct value.
REQ-035 Edge timing: sof rising with half_n=0 only on the sof_pulse cycle -> that cycle is counted in the new frame (sample n+1), not in sample n.
